// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution unit: opcodes, BHT counter
// encodings, FSM states and the saturating counter update helper.
package br_pkg;

    localparam logic [2:0] BR_EQ   = 3'd0;
    localparam logic [2:0] BR_NE   = 3'd1;
    localparam logic [2:0] BR_LT   = 3'd2;
    localparam logic [2:0] BR_GE   = 3'd3;
    localparam logic [2:0] BR_LTU  = 3'd4;
    localparam logic [2:0] BR_GEU  = 3'd5;
    localparam logic [2:0] BR_JAL  = 3'd6;
    localparam logic [2:0] BR_JALR = 3'd7;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // Two-bit saturating counter step towards the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one saturating write port.
import br_pkg::*;

module br_bht #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr_r [ENTRIES];

    // Read returns the stored value; a same-edge write is not bypassed.
    assign rd_taken = ctr_r[rd_idx][1];

    // Counter array: reset to weakly not-taken, saturating update on write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= CTR_WNT;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= ctr_next(ctr_r[wr_idx], wr_taken);
        end else begin
            ctr_r[wr_idx] <= ctr_r[wr_idx];
        end
    end

endmodule

// File: rtl/br_predict_unit.sv
// Branch resolution unit: resolves RISC-V branches and jumps, checks the
// carried prediction, trains the BHT and issues a registered redirect pulse.
import br_pkg::*;

module br_predict_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int BR_OP_WIDTH  = 3,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_WIDTH-1:0]  fetch_pc_i,
    output logic                   predict_taken_o,
    input  logic                   valid_i,
    input  logic [BR_OP_WIDTH-1:0] br_op_i,
    input  logic [DATA_WIDTH-1:0]  rs1_i,
    input  logic [DATA_WIDTH-1:0]  rs2_i,
    input  logic [DATA_WIDTH-1:0]  pc_i,
    input  logic [DATA_WIDTH-1:0]  imm_i,
    input  logic                   pred_taken_i,
    output logic                   redirect_o,
    output logic [DATA_WIDTH-1:0]  redirect_pc_o,
    output logic                   taken_o,
    output logic [DATA_WIDTH-1:0]  link_o,
    output logic                   misalign_o,
    output logic                   flushing_o,
    output logic [CNT_WIDTH-1:0]   mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);
    localparam logic FLUSH_EN = (FLUSH_CYCLES > 0);

    br_state_e             state_r;
    br_state_e             state_s;
    logic [FC_W-1:0]       flush_cnt_r;
    logic [FC_W-1:0]       flush_cnt_s;

    logic                  accept_s;
    logic                  eq_s;
    logic                  lt_s;
    logic                  ltu_s;
    logic                  cond_s;
    logic                  jal_s;
    logic                  jalr_s;
    logic                  taken_s;
    logic [DATA_WIDTH-1:0] br_target_s;
    logic [DATA_WIDTH-1:0] jalr_sum_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic [DATA_WIDTH-1:0] seq_pc_s;
    logic [DATA_WIDTH-1:0] redirect_pc_s;
    logic                  misalign_s;
    logic                  redirect_s;
    logic                  mispred_s;
    logic                  bht_we_s;

    logic                  redirect_r;
    logic [DATA_WIDTH-1:0] redirect_pc_r;
    logic                  taken_r;
    logic [DATA_WIDTH-1:0] link_r;
    logic                  misalign_r;
    logic                  flushing_r;
    logic [CNT_WIDTH-1:0]  mispred_cnt_r;

    assign accept_s    = valid_i && (state_r == RUN);
    assign eq_s        = (rs1_i == rs2_i);
    assign lt_s        = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu_s       = (rs1_i < rs2_i);
    assign br_target_s = pc_i + imm_i;
    assign jalr_sum_s  = rs1_i + imm_i;
    assign seq_pc_s    = pc_i + DATA_WIDTH'(4);
    assign target_s    = jalr_s ? {jalr_sum_s[DATA_WIDTH-1:1], 1'b0} : br_target_s;

    // Opcode decode and direction; unknown encodings resolve as an inert not-taken.
    always_comb begin
        cond_s  = 1'b0;
        jal_s   = 1'b0;
        jalr_s  = 1'b0;
        taken_s = 1'b0;
        case (br_op_i)
            BR_OP_WIDTH'(BR_EQ):   begin cond_s = 1'b1; taken_s = eq_s;   end
            BR_OP_WIDTH'(BR_NE):   begin cond_s = 1'b1; taken_s = !eq_s;  end
            BR_OP_WIDTH'(BR_LT):   begin cond_s = 1'b1; taken_s = lt_s;   end
            BR_OP_WIDTH'(BR_GE):   begin cond_s = 1'b1; taken_s = !lt_s;  end
            BR_OP_WIDTH'(BR_LTU):  begin cond_s = 1'b1; taken_s = ltu_s;  end
            BR_OP_WIDTH'(BR_GEU):  begin cond_s = 1'b1; taken_s = !ltu_s; end
            BR_OP_WIDTH'(BR_JAL):  begin jal_s  = 1'b1; taken_s = 1'b1;   end
            BR_OP_WIDTH'(BR_JALR): begin jalr_s = 1'b1; taken_s = 1'b1;   end
            default:               begin taken_s = 1'b0;                  end
        endcase
    end

    // Redirect decision: a misaligned taken target suppresses everything else.
    always_comb begin
        misalign_s    = 1'b0;
        redirect_s    = 1'b0;
        mispred_s     = 1'b0;
        bht_we_s      = 1'b0;
        redirect_pc_s = taken_s ? target_s : seq_pc_s;
        if (accept_s) begin
            if (taken_s && target_s[1]) begin
                misalign_s = 1'b1;
            end else begin
                bht_we_s = cond_s;
                if (jalr_s) begin
                    redirect_s = 1'b1;
                end else if ((cond_s || jal_s) && (taken_s != pred_taken_i)) begin
                    redirect_s = 1'b1;
                    mispred_s  = 1'b1;
                end else begin
                    redirect_s = 1'b0;
                end
            end
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Flush FSM next state: the window counter drops back to RUN once it reaches 1.
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            RUN: begin
                if (redirect_s && FLUSH_EN) begin
                    state_s     = FLUSH;
                    flush_cnt_s = FLUSH_LOAD;
                end else begin
                    state_s     = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt_r <= FC_W'(1)) begin
                    state_s     = RUN;
                    flush_cnt_s = {FC_W{1'b0}};
                end else begin
                    flush_cnt_s = flush_cnt_r - FC_W'(1);
                end
            end
            default: begin
                state_s     = RUN;
                flush_cnt_s = {FC_W{1'b0}};
            end
        endcase
    end

    // FSM state and window counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= RUN;
            flush_cnt_r <= {FC_W{1'b0}};
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
        end
    end

    // Output registers; taken/link hold the last accepted resolve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= {DATA_WIDTH{1'b0}};
            taken_r       <= 1'b0;
            link_r        <= {DATA_WIDTH{1'b0}};
            misalign_r    <= 1'b0;
            flushing_r    <= 1'b0;
            mispred_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            redirect_r <= redirect_s;
            misalign_r <= misalign_s;
            flushing_r <= (state_s == FLUSH);
            if (redirect_s) begin
                redirect_pc_r <= redirect_pc_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
            if (accept_s) begin
                taken_r <= taken_s;
                link_r  <= seq_pc_s;
            end else begin
                taken_r <= taken_r;
                link_r  <= link_r;
            end
            if (mispred_s && (mispred_cnt_r != {CNT_WIDTH{1'b1}})) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_WIDTH'(1);
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end
    end

    br_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (fetch_pc_i[IDX_W+1:2]),
        .rd_taken (predict_taken_o),
        .wr_en    (bht_we_s),
        .wr_idx   (pc_i[IDX_W+1:2]),
        .wr_taken (taken_s)
    );

    assign redirect_o    = redirect_r;
    assign redirect_pc_o = redirect_pc_r;
    assign taken_o       = taken_r;
    assign link_o        = link_r;
    assign misalign_o    = misalign_r;
    assign flushing_o    = flushing_r;
    assign mispred_cnt_o = mispred_cnt_r;

endmodule

// File: tb/tb_br_predict_unit.sv
// Directed bench for br_predict_unit: a resolve vector table plus hand-written
// sequences for the flush window, BHT saturation and reset corner cases.
import br_pkg::*;

module tb_br_predict_unit;

    localparam int DW = 32;
    localparam int FC = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] fetch_pc;
    logic          predict_taken;
    logic          valid;
    logic [2:0]    br_op;
    logic [DW-1:0] rs1, rs2, pc, imm;
    logic          pred_taken;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          taken;
    logic [DW-1:0] link;
    logic          misalign;
    logic          flushing;
    logic [1:0]    mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    br_predict_unit #(
        .DATA_WIDTH   (DW),
        .BR_OP_WIDTH  (3),
        .BHT_ENTRIES  (64),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .fetch_pc_i      (fetch_pc),
        .predict_taken_o (predict_taken),
        .valid_i         (valid),
        .br_op_i         (br_op),
        .rs1_i           (rs1),
        .rs2_i           (rs2),
        .pc_i            (pc),
        .imm_i           (imm),
        .pred_taken_i    (pred_taken),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .taken_o         (taken),
        .link_o          (link),
        .misalign_o      (misalign),
        .flushing_o      (flushing),
        .mispred_cnt_o   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        e_taken;
        logic        e_redir;
        logic        e_mis;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic pr);
        br_op      = op;
        rs1        = a;
        rs2        = b;
        pc         = p;
        imm        = i;
        pred_taken = pr;
        valid      = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_flush();
        valid = 1'b0;
        repeat (FC) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_redirect"}, 32'(redirect), 32'd0);
        check({tag, "_rpc"},      redirect_pc,   32'd0);
        check({tag, "_taken"},    32'(taken),    32'd0);
        check({tag, "_link"},     link,          32'd0);
        check({tag, "_misalign"}, 32'(misalign), 32'd0);
        check({tag, "_flushing"}, 32'(flushing), 32'd0);
        check({tag, "_cnt"},      32'(mispred_cnt), 32'd0);
    endtask

    initial begin
        //          op       rs1           rs2           pc        imm           pred  tk    rd    mis   rpc
        vecs[0] = '{BR_NE,   32'd5,        32'd5,        32'h200,  32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{BR_LTU,  32'hFFFFFFFF, 32'd1,        32'h204,  32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{BR_LT,   32'hFFFFFFFF, 32'd1,        32'h208,  32'h10,       1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{BR_GE,   32'd1,        32'hFFFFFFFF, 32'h300,  32'hFFFFFFF0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2F0};
        vecs[4] = '{BR_JAL,  32'd0,        32'd0,        32'h500,  32'h100,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{BR_JAL,  32'd0,        32'd0,        32'h500,  32'h102,      1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{BR_JALR, 32'h1001,     32'd0,        32'h600,  32'd3,        1'b1, 1'b1, 1'b1, 1'b0, 32'h1004};
        vecs[7] = '{BR_JALR, 32'h1001,     32'd0,        32'h600,  32'd2,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8] = '{BR_GEU,  32'd1,        32'hFFFFFFFF, 32'h400,  32'd8,        1'b1, 1'b0, 1'b1, 1'b0, 32'h404};
        vecs[9] = '{BR_EQ,   32'd3,        32'd4,        32'h700,  32'h40,       1'b1, 1'b0, 1'b1, 1'b0, 32'h704};

        rst      = 1'b1;
        valid    = 1'b0;
        br_op    = BR_EQ;
        rs1      = 32'd0;
        rs2      = 32'd0;
        pc       = 32'd0;
        imm      = 32'd0;
        pred_taken = 1'b0;
        fetch_pc = 32'h100;
        repeat (2) step();
        check_all_zero("reset");
        rst = 1'b0;
        check("reset_predict", 32'(predict_taken), 32'd0);

        // First mispredicting BEQ opens a flush window.
        drive(BR_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        step();
        exp_cnt = 1;
        check("beq_redirect", 32'(redirect),    32'd1);
        check("beq_rpc",      redirect_pc,      32'h120);
        check("beq_cnt",      32'(mispred_cnt), 32'(exp_cnt));
        check("beq_flushing", 32'(flushing),    32'd1);
        check("beq_link",     link,             32'h104);
        idle_flush();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
            step();
            if (vecs[i].e_redir && vecs[i].op != BR_JALR && exp_cnt < 3) exp_cnt++;
            check($sformatf("v%0d_taken", i),    32'(taken),    32'(vecs[i].e_taken));
            check($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
            check($sformatf("v%0d_misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
            check($sformatf("v%0d_link", i),     link,          vecs[i].pc + 32'd4);
            check($sformatf("v%0d_cnt", i),      32'(mispred_cnt), 32'(exp_cnt));
            if (vecs[i].e_redir) check($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
            idle_flush();
        end

        // Flush window: a mispredicting BLT held on valid is ignored for FC cycles.
        drive(BR_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        step();
        check("win_open", 32'(redirect), 32'd1);
        fetch_pc = 32'h880;
        drive(BR_LT, 32'd1, 32'd2, 32'h880, 32'h10, 1'b0);
        step();
        check("win_skip1_redirect", 32'(redirect), 32'd0);
        check("win_skip1_flushing", 32'(flushing), 32'd1);
        step();
        check("win_skip2_redirect", 32'(redirect), 32'd0);
        check("win_skip2_flushing", 32'(flushing), 32'd0);
        check("win_bht_unchanged",  32'(predict_taken), 32'd0);
        step();
        check("win_accept_redirect", 32'(redirect), 32'd1);
        check("win_accept_rpc",      redirect_pc,   32'h890);
        check("win_accept_bht",      32'(predict_taken), 32'd1);
        check("win_cnt_sat",         32'(mispred_cnt), 32'd3);
        idle_flush();

        // BHT entry 16 saturation with back-to-back correctly predicted BNEs.
        fetch_pc = 32'h40;
        drive(BR_NE, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
        #1;
        check("bht_same_cycle_read", 32'(predict_taken), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("bht_taken%0d_predict", k),  32'(predict_taken), 32'd1);
            check($sformatf("bht_taken%0d_redirect", k), 32'(redirect),      32'd0);
            check($sformatf("bht_taken%0d_taken", k),    32'(taken),         32'd1);
        end
        drive(BR_NE, 32'd1, 32'd1, 32'h40, 32'h8, 1'b0);
        step();
        check("bht_dec1_predict",  32'(predict_taken), 32'd1);
        check("bht_dec1_redirect", 32'(redirect),      32'd0);
        check("bht_dec1_taken",    32'(taken),         32'd0);
        step();
        check("bht_dec2_predict",  32'(predict_taken), 32'd0);

        // Reset in the middle of a redirect pulse.
        drive(BR_NE, 32'd1, 32'd2, 32'h40, 32'h8, 1'b0);
        step();
        check("rstp_redirect", 32'(redirect),      32'd1);
        check("rstp_predict",  32'(predict_taken), 32'd1);
        valid = 1'b0;
        rst   = 1'b1;
        step();
        check_all_zero("rst_pulse");
        check("rst_pulse_predict", 32'(predict_taken), 32'd0);
        rst = 1'b0;

        // Reset while the flush window is still open.
        drive(BR_NE, 32'd1, 32'd2, 32'h40, 32'h8, 1'b0);
        step();
        check("rstf_cnt", 32'(mispred_cnt), 32'd1);
        valid = 1'b0;
        step();
        check("rstf_flushing", 32'(flushing), 32'd1);
        check("rstf_redirect", 32'(redirect), 32'd0);
        rst = 1'b1;
        step();
        check_all_zero("rst_flush");
        check("rst_flush_predict", 32'(predict_taken), 32'd0);
        rst = 1'b0;

        // Table is back at weakly not-taken: one taken resolve flips the prediction.
        drive(BR_NE, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
        step();
        valid = 1'b0;
        check("post_rst_redirect", 32'(redirect),      32'd0);
        check("post_rst_predict",  32'(predict_taken), 32'd1);
        check("post_rst_cnt",      32'(mispred_cnt),   32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
